// File: rtl/splitter_fanout_scheduler_if.sv
// Requester-side and tree-side signal bundle of the splitter fan-out scheduler.
// The master side drives requests and masks; the slave side is the scheduler itself.
interface splitter_fanout_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] mask;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           pulse_out;
    logic                 pulse_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic [CNT_W-1:0]     fire_count;

    modport master (
        output req, mask,
        input  ack, pulse_out, pulse_valid, grant_id, busy, fire_count
    );

    modport slave (
        input  req, mask,
        output ack, pulse_out, pulse_valid, grant_id, busy, fire_count
    );
endinterface

// File: rtl/splitter_fanout_scheduler.sv
// Round-robin scheduler that fires one gated lane pulse into the 8-lane splitter
// tree per grant and then holds the tree idle for a recovery gap.
module splitter_fanout_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    splitter_fanout_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    generate
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("GAP_CYCLES must be at least 1");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("NUM_REQ must be in the range 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [ID_W-1:0]    r_last;
    logic [NUM_REQ-1:0] r_ack;
    logic [7:0]         r_pulse_out;
    logic               r_pulse_valid;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_busy;
    logic [CNT_W-1:0]   r_fire_count;

    logic [7:0]           w_lane_mask [NUM_REQ];
    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_winner;
    logic [7:0]           w_win_mask;
    logic                 w_arb;
    logic                 w_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane_mask[gi] = bus.mask[8*gi +: 8];
        end
    endgenerate

    // Rotate so bit 0 is the requester just after the last grant; the lowest set
    // bit of the rotated vector is then the round-robin winner.
    assign w_req2 = {bus.req, bus.req};
    assign w_rot  = NUM_REQ'(w_req2 >> ({1'b0, r_last} + (ID_W+1)'(1)));

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_last} + (ID_W+1)'(1) + {1'b0, w_off};
    assign w_winner   = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                      : ID_W'(w_sum);
    assign w_win_mask = w_lane_mask[w_winner];

    assign w_arb   = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap_cnt == '0));
    assign w_grant = w_arb && (bus.req != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gap_cnt     <= '0;
            r_last        <= ID_W'(NUM_REQ - 1);
            r_ack         <= '0;
            r_pulse_out   <= '0;
            r_pulse_valid <= 1'b0;
            r_grant_id    <= '0;
            r_busy        <= 1'b0;
            r_fire_count  <= '0;
        end else begin
            r_ack         <= '0;
            r_pulse_out   <= '0;
            r_pulse_valid <= 1'b0;
            if (w_grant) begin
                // Outputs for the FIRE cycle are loaded here so they are registered.
                r_state       <= S_FIRE;
                r_last        <= w_winner;
                r_grant_id    <= w_winner;
                r_ack         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                r_pulse_out   <= w_win_mask;
                r_pulse_valid <= (w_win_mask != 8'h00);
                r_busy        <= 1'b1;
                if ((w_win_mask != 8'h00) && (r_fire_count != '1)) begin
                    r_fire_count <= r_fire_count + CNT_W'(1);
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_FIRE: begin
                        // A zero-mask grant never touched the tree, so no recovery.
                        if (r_pulse_valid) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt != '0) begin
                            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ack         = r_ack;
    assign bus.pulse_out   = r_pulse_out;
    assign bus.pulse_valid = r_pulse_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
    assign bus.fire_count  = r_fire_count;
endmodule
